// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 2-flop rx synchronizer, oversampling tick generator,
// start/data/parity/stop FSM, one-entry holding register and sticky W1C flags.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_odd_i,
    input  logic             rx_i,
    output logic [7:0]       frame_data_o,
    output logic             frame_perr_o,
    output logic             frame_valid_o,
    input  logic             frame_ready_i,
    input  logic [3:0]       irq_mask_i,
    input  logic [3:0]       irq_clr_i,
    output logic [3:0]       irq_flags_o,
    output logic             rx_irq_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    function automatic logic xor_reduce8(input logic [7:0] v);
        return ^v;
    endfunction

    state_t           state_q;
    logic [1:0]       sync_q;
    logic [DIV_W-1:0] divcnt_q;
    logic [CNT_W-1:0] scnt_q;
    logic [2:0]       bcnt_q;
    logic [7:0]       shift_q;
    logic             perr_q;
    logic [7:0]       frame_data_q;
    logic             frame_perr_q;
    logic             frame_valid_q;
    logic [3:0]       flags_q;

    logic             rx_s;
    logic             tick_s;
    logic             mid_s;
    logic             full_s;
    logic             accept_s;
    logic             stop_ok_s;
    logic             stop_bad_s;
    logic             commit_s;
    logic [3:0]       flag_set_s;

    assign rx_s = sync_q[1];

    // Sample-point decode, commit decision and flag-set vector
    always_comb begin
        tick_s     = (divcnt_q == cfg_div_i);
        mid_s      = tick_s && (scnt_q == HALF_M1);
        full_s     = tick_s && (scnt_q == FULL_M1);
        accept_s   = !frame_valid_q || frame_ready_i;
        stop_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
        if (cfg_en_i && (state_q == S_STOP) && full_s) begin
            stop_ok_s  = rx_s;
            stop_bad_s = !rx_s;
        end else begin
            stop_ok_s  = 1'b0;
            stop_bad_s = 1'b0;
        end
        commit_s   = stop_ok_s && accept_s;
        flag_set_s = {stop_ok_s && !accept_s, stop_bad_s, commit_s && perr_q, commit_s};
    end

    // Two-flop synchronizer for the asynchronous rx line (idles high)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Baud divider: only runs while a frame is in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divcnt_q <= '0;
        end else if (!cfg_en_i || (state_q == S_IDLE) || tick_s) begin
            divcnt_q <= '0;
        end else begin
            divcnt_q <= divcnt_q + DIV_W'(1);
        end
    end

    // Receive FSM, holding register and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            scnt_q        <= '0;
            bcnt_q        <= 3'd0;
            shift_q       <= 8'd0;
            perr_q        <= 1'b0;
            frame_data_q  <= 8'd0;
            frame_perr_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            flags_q       <= 4'd0;
        end else begin
            // New events win over a simultaneous clear
            flags_q <= (flags_q & ~irq_clr_i) | flag_set_s;

            if (commit_s) begin
                frame_data_q  <= shift_q;
                frame_perr_q  <= perr_q;
                frame_valid_q <= 1'b1;
            end else if (frame_valid_q && frame_ready_i) begin
                frame_valid_q <= 1'b0;
            end else begin
                frame_valid_q <= frame_valid_q;
            end

            if (!cfg_en_i) begin
                state_q <= S_IDLE;
                scnt_q  <= '0;
                bcnt_q  <= 3'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q <= S_START;
                            scnt_q  <= '0;
                        end
                    end
                    S_START: begin
                        if (mid_s) begin
                            // A start bit that is high again at mid-bit is a glitch
                            if (rx_s) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_DATA;
                                scnt_q  <= '0;
                                bcnt_q  <= 3'd0;
                                perr_q  <= 1'b0;
                            end
                        end else if (tick_s) begin
                            scnt_q <= scnt_q + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (full_s) begin
                            shift_q[bcnt_q] <= rx_s;
                            scnt_q          <= '0;
                            if (bcnt_q == 3'd7) begin
                                state_q <= cfg_parity_en_i ? S_PARITY : S_STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 3'd1;
                            end
                        end else if (tick_s) begin
                            scnt_q <= scnt_q + CNT_W'(1);
                        end
                    end
                    S_PARITY: begin
                        if (full_s) begin
                            perr_q  <= (xor_reduce8(shift_q) ^ rx_s) != cfg_parity_odd_i;
                            scnt_q  <= '0;
                            state_q <= S_STOP;
                        end else if (tick_s) begin
                            scnt_q <= scnt_q + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (full_s) begin
                            scnt_q  <= '0;
                            state_q <= rx_s ? S_IDLE : S_BREAK;
                        end else if (tick_s) begin
                            scnt_q <= scnt_q + CNT_W'(1);
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign frame_data_o  = frame_data_q;
    assign frame_perr_o  = frame_perr_q;
    assign frame_valid_o = frame_valid_q;
    assign irq_flags_o   = flags_q;
    assign rx_irq_o      = |(flags_q & irq_mask_i);
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized frames
// scored against a frame-level model of the receiver.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic        rx;
    logic [7:0]  frame_data;
    logic        frame_perr;
    logic        frame_valid;
    logic        frame_ready;
    logic [3:0]  irq_mask;
    logic [3:0]  irq_clr;
    logic [3:0]  irq_flags;
    logic        rx_irq;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] m_flags;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_valid;

    uart_rx_ctrl #(.OVERSAMPLE(16), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_parity_en_i(cfg_parity_en), .cfg_parity_odd_i(cfg_parity_odd),
        .rx_i(rx), .frame_data_o(frame_data), .frame_perr_o(frame_perr),
        .frame_valid_o(frame_valid), .frame_ready_i(frame_ready),
        .irq_mask_i(irq_mask), .irq_clr_i(irq_clr), .irq_flags_o(irq_flags),
        .rx_irq_o(rx_irq), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick_n(n);
    endtask

    task automatic pulse_clr(input logic [3:0] v);
        irq_clr = v;
        tick_n(1);
        irq_clr = 4'd0;
    endtask

    // Edges from the first low rx cycle to the first frame_valid rise
    function automatic int latency(input int div, input bit pen);
        return 3 + (div + 1) * (8 + 16 * (9 + int'(pen)));
    endfunction

    // Drives one full frame; reports edge index of a frame_valid rise and valid-high cycles
    task automatic send_frame(input logic [7:0] d, input int div, input bit pen, input bit pbit,
                              input bit sbit, output int rise_at, output int vcyc);
        logic [10:0] seq;
        int          nb;
        int          t_bit;
        int          idx;
        logic        prev_v;
        seq    = pen ? {sbit, pbit, d, 1'b0} : {1'b1, sbit, d, 1'b0};
        nb     = pen ? 11 : 10;
        t_bit  = 16 * (div + 1);
        rise_at = -1;
        vcyc   = 0;
        idx    = 0;
        prev_v = frame_valid;
        for (int b = 0; b < nb; b++) begin
            rx = seq[b];
            for (int c = 0; c < t_bit; c++) begin
                @(posedge clk);
                #1;
                idx++;
                if (frame_valid) vcyc++;
                if (frame_valid && !prev_v && rise_at < 0) rise_at = idx;
                prev_v = frame_valid;
            end
        end
    endtask

    // Frame-level outcome: break, overrun or load, then drain if the FIFO is ready
    task automatic model_frame(input logic [7:0] d, input bit pen, input bit odd, input bit pbit,
                               input bit sbit, input bit ready);
        if (!sbit) begin
            m_flags[2] = 1'b1;
        end else if (m_valid && !ready) begin
            m_flags[3] = 1'b1;
        end else begin
            m_data = d;
            m_perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
            m_flags[0] = 1'b1;
            if (m_perr) m_flags[1] = 1'b1;
        end
        m_valid = ready ? 1'b0 : (sbit ? 1'b1 : m_valid);
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, ".data"},  32'(frame_data),  32'(m_data));
        chk({pfx, ".perr"},  32'(frame_perr),  32'(m_perr));
        chk({pfx, ".valid"}, 32'(frame_valid), 32'(m_valid));
        chk({pfx, ".flags"}, 32'(irq_flags),   32'(m_flags));
        chk({pfx, ".irq"},   32'(rx_irq),      32'(|(m_flags & irq_mask)));
        chk({pfx, ".busy"},  32'(busy),        32'd0);
    endtask

    initial begin
        int         rise;
        int         vc;
        int         r2;
        int         v2;
        int         exp_rise;
        bit         saw_busy;
        logic [7:0] d;
        logic [3:0] clr;
        logic [3:0] saved_flags;
        bit         pen;
        bit         odd;
        bit         pbit;
        bit         sbit;
        bit         rdy;
        int         div;

        rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd0; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; rx = 1'b1; frame_ready = 1'b1; irq_mask = 4'hF; irq_clr = 4'd0;
        m_flags = 4'd0; m_data = 8'd0; m_perr = 1'b0; m_valid = 1'b0;
        tick_n(4);
        rst_n = 1'b1;
        tick_n(1);
        chk("rst.data", 32'(frame_data), 32'h0);
        chk("rst.valid", 32'(frame_valid), 32'h0);
        chk("rst.flags", 32'(irq_flags), 32'h0);
        chk("rst.irq", 32'(rx_irq), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);

        // 1: 0xA5, no parity, divider 0
        irq_mask = 4'd0; cfg_en = 1'b1;
        idle(4);
        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b1, rise, vc);
        model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        chk("t1.latency", 32'(rise), 32'd155);
        chk("t1.vcycles", 32'(vc), 32'd1);
        chk("t1.data_const", 32'(frame_data), 32'hA5);
        chk("t1.flags_const", 32'(irq_flags), 32'b0001);
        check_state("t1");
        pulse_clr(4'hF);
        m_flags = 4'd0;

        // 2: even parity, 0x07 with parity bit 0 -> parity error
        cfg_en = 1'b0; tick_n(1);
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_en = 1'b1; irq_mask = 4'b0010;
        idle(4);
        send_frame(8'h07, 0, 1'b1, 1'b0, 1'b1, rise, vc);
        model_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        chk("t2.latency", 32'(rise), 32'd171);
        chk("t2.perr_const", 32'(frame_perr), 32'h1);
        chk("t2.irq_const", 32'(rx_irq), 32'h1);
        check_state("t2");
        pulse_clr(4'b0010);
        m_flags[1] = 1'b0;
        chk("t2.clr_flag1", 32'(irq_flags[1]), 32'h0);
        chk("t2.clr_flags", 32'(irq_flags), 32'(m_flags));

        // 3: short low glitch on rx
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        chk("t3.saw_busy", 32'(saw_busy), 32'h1);
        check_state("t3");

        // 4: stop bit low, line held low -> framing error and BREAK
        cfg_en = 1'b0; tick_n(1);
        cfg_parity_en = 1'b0; cfg_en = 1'b1; irq_mask = 4'b0100;
        idle(4);
        send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0, rise, vc);
        tick_n(284);
        model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4.no_valid", 32'(rise), 32'hFFFF_FFFF);
        chk("t4.busy_break", 32'(busy), 32'h1);
        chk("t4.ferr", 32'(irq_flags[2]), 32'h1);
        idle(5);
        check_state("t4");

        // 5: FIFO stalled -> overrun keeps first byte
        pulse_clr(4'hF);
        m_flags = 4'd0;
        frame_ready = 1'b0; irq_mask = 4'b1000;
        send_frame(8'h11, 0, 1'b0, 1'b0, 1'b1, rise, vc);
        model_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        send_frame(8'h22, 0, 1'b0, 1'b0, 1'b1, rise, vc);
        model_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        chk("t5.data_const", 32'(frame_data), 32'h11);
        chk("t5.overrun", 32'(irq_flags[3]), 32'h1);
        check_state("t5");
        frame_ready = 1'b1;
        chk("t5.valid_before", 32'(frame_valid), 32'h1);
        tick_n(1);
        m_valid = 1'b0;
        chk("t5.valid_after", 32'(frame_valid), 32'h0);

        // 6: divider 3, then abort a frame by dropping the enable
        cfg_en = 1'b0; tick_n(1);
        cfg_div = 16'd3; cfg_en = 1'b1;
        idle(4);
        send_frame(8'h3C, 3, 1'b0, 1'b0, 1'b1, rise, vc);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        chk("t6.latency", 32'(rise), 32'd611);
        chk("t6.data_const", 32'(frame_data), 32'h3C);
        check_state("t6");
        saved_flags = irq_flags;
        fork
            send_frame(8'hC3, 3, 1'b0, 1'b0, 1'b1, r2, v2);
            begin
                tick_n(200);
                cfg_en = 1'b0;
            end
        join
        idle(5);
        chk("t6.abort_rise", 32'(r2), 32'hFFFF_FFFF);
        chk("t6.abort_flags", 32'(irq_flags), 32'(saved_flags));
        check_state("t6a");
        cfg_en = 1'b1;
        idle(10);
        check_state("t6b");

        // Randomized frames against the model
        for (int it = 0; it < 25; it++) begin
            d    = 8'($urandom_range(0, 255));
            div  = int'($urandom_range(0, 3));
            pen  = 1'($urandom_range(0, 1));
            odd  = 1'($urandom_range(0, 1));
            pbit = (^d) ^ odd ^ ($urandom_range(0, 2) == 0);
            sbit = ($urandom_range(0, 5) != 0);
            rdy  = 1'($urandom_range(0, 1));
            clr  = 4'($urandom_range(0, 15));
            cfg_en = 1'b0; tick_n(1);
            cfg_div = 16'(div); cfg_parity_en = pen; cfg_parity_odd = odd; cfg_en = 1'b1;
            frame_ready = rdy; irq_mask = 4'($urandom_range(0, 15));
            pulse_clr(clr);
            m_flags = m_flags & ~clr;
            idle(8);
            if (rdy) m_valid = 1'b0;
            exp_rise = (sbit && (rdy || !m_valid)) ? latency(div, pen) : -1;
            send_frame(d, div, pen, pbit, sbit, rise, vc);
            model_frame(d, pen, odd, pbit, sbit, rdy);
            idle(40);
            chk("rnd.latency", 32'(rise), 32'(exp_rise));
            check_state("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
